// File: rtl/pmem_write_buffer.sv
// rtl/pmem_write_buffer.sv - eviction write buffer between the arbiter port and physical memory
// Coalesces block writebacks, serves read hits locally, and drains buffered lines in FIFO order.
module pmem_write_buffer #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     up_read,
    input  logic                     up_write,
    input  logic [15:0]              up_address,
    input  logic [127:0]             up_wdata,
    output logic [127:0]             up_rdata,
    output logic                     up_resp,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [15:0]              mem_address,
    output logic [127:0]             mem_wdata,
    input  logic [127:0]             mem_rdata,
    input  logic                     mem_resp,
    output logic [$clog2(DEPTH):0]   buf_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, READ_MEM, DRAIN, RESP} state_t;

    state_t         state;
    state_t         state_next;

    logic [DEPTH-1:0] valid;
    logic [11:0]      tags  [DEPTH];
    logic [127:0]     datas [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW:0]      count;
    logic [11:0]      rd_block;

    logic [11:0]      block;
    logic             hit;
    logic [PW-1:0]    hit_idx;
    logic             wr_hit;
    logic             wr_enq;
    logic             deq;
    logic             rd_latch;
    logic [11:0]      rd_block_next;
    logic [127:0]     up_rdata_next;
    logic [15:0]      mem_address_next;
    logic [127:0]     mem_wdata_next;
    logic             unused_offset;

    assign block         = up_address[15:4];
    assign unused_offset = ^up_address[3:0];
    assign buf_count     = count;

    // Coalescing on every write keeps tags unique, so at most one entry can hit.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && tags[i] == block) begin
                hit     = 1'b1;
                hit_idx = PW'(i);
            end
        end
    end

    always_comb begin
        state_next    = state;
        wr_hit        = 1'b0;
        wr_enq        = 1'b0;
        deq           = 1'b0;
        rd_latch      = 1'b0;
        up_rdata_next = up_rdata;
        case (state)
            IDLE: begin
                // A simultaneous read and write is illegal; the write wins.
                if (up_write) begin
                    if (hit) begin
                        wr_hit     = 1'b1;
                        state_next = RESP;
                    end else if (count < FULL) begin
                        wr_enq     = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = DRAIN;
                    end
                end else if (up_read) begin
                    if (hit) begin
                        up_rdata_next = datas[hit_idx];
                        state_next    = RESP;
                    end else begin
                        rd_latch   = 1'b1;
                        state_next = READ_MEM;
                    end
                end else if (count != '0) begin
                    state_next = DRAIN;
                end
            end
            READ_MEM: begin
                if (mem_resp) begin
                    up_rdata_next = mem_rdata;
                    state_next    = RESP;
                end
            end
            DRAIN: begin
                if (mem_resp) begin
                    deq        = 1'b1;
                    state_next = IDLE;
                end
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory-side outputs are registered from the next state so they track it exactly.
    always_comb begin
        rd_block_next    = rd_latch ? block : rd_block;
        mem_address_next = '0;
        mem_wdata_next   = '0;
        if (state_next == READ_MEM) begin
            mem_address_next = {rd_block_next, 4'b0};
        end else if (state_next == DRAIN) begin
            mem_address_next = {tags[head], 4'b0};
            mem_wdata_next   = datas[head];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            valid       <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            rd_block    <= '0;
            up_rdata    <= '0;
            up_resp     <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            state       <= state_next;
            rd_block    <= rd_block_next;
            up_rdata    <= up_rdata_next;
            up_resp     <= (state_next == RESP);
            mem_read    <= (state_next == READ_MEM);
            mem_write   <= (state_next == DRAIN);
            mem_address <= mem_address_next;
            mem_wdata   <= mem_wdata_next;
            if (wr_hit) begin
                datas[hit_idx] <= up_wdata;
            end
            if (wr_enq) begin
                valid[tail] <= 1'b1;
                tags[tail]  <= block;
                datas[tail] <= up_wdata;
                tail        <= tail + 1'b1;
                count       <= count + 1'b1;
            end
            if (deq) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
                count       <= count - 1'b1;
            end
        end
    end

endmodule
